// File: rtl/div_iter_unit.sv
// ---------------------------------------------------------------------------
// div_iter_unit
//
// Iterative 32-bit radix-2 restoring divider. It sits at the responder end of
// the divider stream interface driven by the execute stage. The execute stage
// presents the divisor and the dividend on independent valid/ready channels.
// It then stalls until the one-cycle result pulse, and writes the quotient to
// LO and the remainder to HI.
//
// One instance is built per signedness: SIGNED=1 for DIV, SIGNED=0 for DIVU.
//
// Ports:
//   clk                     rising-edge clock
//   resetn                  asynchronous active-low reset
//   s_axis_divisor_tdata    divisor operand (32)
//   s_axis_divisor_tvalid   divisor valid
//   s_axis_divisor_tready   divisor ready (high while idle and not yet captured)
//   s_axis_dividend_tdata   dividend operand (32)
//   s_axis_dividend_tvalid  dividend valid
//   s_axis_dividend_tready  dividend ready (high while idle and not yet captured)
//   m_axis_dout_tdata       {quotient[63:32], remainder[31:0]}, held until next result
//   m_axis_dout_tvalid      one-cycle result pulse, no back-pressure
//
// Build option:
//   DIV_ZERO_FAST_EN  when defined, a zero divisor skips the iterations. The
//                     divide-by-zero result is then presented in the cycle
//                     after the capture edge.
// ---------------------------------------------------------------------------
module div_iter_unit #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  output logic [63:0] m_axis_dout_tdata,
  output logic        m_axis_dout_tvalid
);

`ifdef DIV_ZERO_FAST_EN
  localparam bit ZERO_FAST = 1'b1;
`else
  localparam bit ZERO_FAST = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t      state, state_next;

  // Operand capture: each channel is held here independently until the
  // operation that uses it completes.
  logic        divisor_captured, dividend_captured;
  logic [31:0] divisor_hold, dividend_hold;

  // Iteration datapath. The quo register starts out holding the dividend
  // magnitude. Dividend bits shift out of its top while quotient bits shift
  // in at its bottom.
  logic [31:0] divisor_mag;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [5:0]  cnt;
  logic        sign_q, sign_r;
  logic [63:0] dout;

  // Combinational helpers
  logic        divisor_fire, dividend_fire;
  logic        start, fast_zero, last_iter;
  logic [31:0] op_a, op_b;
  logic        neg_a, neg_b;
  logic [31:0] abs_a, abs_b;
  logic [32:0] shifted, trial;
  logic [31:0] rem_next, quo_next;
  logic [31:0] q_fin, r_fin;
  logic [31:0] zero_q;

  // ---------------------------------------------------------------------
  // Capture, operand selection and one restoring iteration
  // ---------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a value at the top of
  // the block. Any path that leaves a signal unassigned would infer a latch.
  always_comb begin
    divisor_fire  = 1'b0;
    dividend_fire = 1'b0;
    start         = 1'b0;
    fast_zero     = 1'b0;
    op_a          = '0;
    op_b          = '0;
    neg_a         = 1'b0;
    neg_b         = 1'b0;
    abs_a         = '0;
    abs_b         = '0;
    shifted       = '0;
    trial         = '0;
    rem_next      = rem;
    quo_next      = quo;
    q_fin         = '0;
    r_fin         = '0;
    zero_q        = '0;
    last_iter     = 1'b0;

    divisor_fire  = (state == IDLE) && !divisor_captured  && s_axis_divisor_tvalid;
    dividend_fire = (state == IDLE) && !dividend_captured && s_axis_dividend_tvalid;

    // The operation starts on the edge that completes the pair. The operand
    // already captured comes from its hold register, and the operand arriving
    // now comes straight off the bus.
    start = (state == IDLE)
            && (divisor_captured  || divisor_fire)
            && (dividend_captured || dividend_fire);

    op_a  = dividend_captured ? dividend_hold : s_axis_dividend_tdata;
    op_b  = divisor_captured  ? divisor_hold  : s_axis_divisor_tdata;
    neg_a = SIGNED && op_a[31];
    neg_b = SIGNED && op_b[31];
    // The magnitude of 0x80000000 is still 0x80000000 when read as unsigned,
    // so the most negative operand needs no special case.
    abs_a = neg_a ? (32'd0 - op_a) : op_a;
    abs_b = neg_b ? (32'd0 - op_b) : op_b;

    fast_zero = ZERO_FAST && (op_b == 32'd0);
    // Divide-by-zero quotient: all ones, or +1 once a negative dividend's
    // sign is applied. The remainder is the dividend itself.
    zero_q    = neg_a ? 32'h0000_0001 : 32'hFFFF_FFFF;

    // Restoring step. The partial remainder is always below the divisor, so
    // the shifted value fits in 33 bits and bit 32 of the difference is the
    // borrow. With a zero divisor the shifted value never reaches bit 32,
    // which produces the all-ones quotient and the remainder equal to the
    // dividend without any special case.
    shifted = {rem, quo[31]};
    trial   = shifted - {1'b0, divisor_mag};
    if (!trial[32]) begin
      rem_next = trial[31:0];
      quo_next = {quo[30:0], 1'b1};
    end else begin
      rem_next = shifted[31:0];
      quo_next = {quo[30:0], 1'b0};
    end

    last_iter = (state == CALC) && (cnt == 6'd31);

    // Sign correction on the final iteration. sign_q and sign_r are only ever
    // set when SIGNED=1.
    q_fin = sign_q ? (32'd0 - quo_next) : quo_next;
    r_fin = sign_r ? (32'd0 - rem_next) : rem_next;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = fast_zero ? OUT : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = OUT;
        end
      end
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state always uses non-blocking assignments. Every
  // register then samples values from before the edge, and the order of the
  // statements cannot change the result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  // NOTE: the datapath registers are reset along with the control state.
  // The result bus must read 0 out of reset. The remaining registers are few,
  // so they are cleared as well, which keeps the block free of X after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      divisor_captured  <= 1'b0;
      dividend_captured <= 1'b0;
      divisor_hold      <= '0;
      dividend_hold     <= '0;
      divisor_mag       <= '0;
      rem               <= '0;
      quo               <= '0;
      cnt               <= '0;
      sign_q            <= 1'b0;
      sign_r            <= 1'b0;
      dout              <= '0;
    end else begin
      if (divisor_fire) begin
        divisor_captured <= 1'b1;
        divisor_hold     <= s_axis_divisor_tdata;
      end
      if (dividend_fire) begin
        dividend_captured <= 1'b1;
        dividend_hold     <= s_axis_dividend_tdata;
      end

      if (start) begin
        cnt         <= '0;
        rem         <= '0;
        quo         <= abs_a;
        divisor_mag <= abs_b;
        sign_q      <= neg_a ^ neg_b;
        sign_r      <= neg_a;
        if (fast_zero) begin
          // Skip the iterations. These assignments come after the capture
          // above, so they override it and free both channels here.
          dout              <= {zero_q, op_a};
          divisor_captured  <= 1'b0;
          dividend_captured <= 1'b0;
        end
      end

      if (state == CALC) begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= cnt + 6'd1;
        if (last_iter) begin
          dout              <= {q_fin, r_fin};
          divisor_captured  <= 1'b0;
          dividend_captured <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign s_axis_divisor_tready  = (state == IDLE) && !divisor_captured;
  assign s_axis_dividend_tready = (state == IDLE) && !dividend_captured;
  assign m_axis_dout_tdata      = dout;
  assign m_axis_dout_tvalid     = (state == OUT);

endmodule

// File: tb/tb_div_iter_unit.sv
// ---------------------------------------------------------------------------
// tb_div_iter_unit
//
// Two instances run side by side: index 0 is SIGNED=0 (DIVU) and index 1 is
// SIGNED=1 (DIV). A behavioural model tracks operand capture, timing and
// results using plain arithmetic. A compare loop checks both ready outputs,
// the valid pulse and the result bus of both instances on every falling edge.
// Directed tests also check literal results and latencies.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] a_data  [2];   // dividend
  logic [31:0] b_data  [2];   // divisor
  logic        a_valid [2];
  logic        b_valid [2];
  logic        a_ready [2];
  logic        b_ready [2];
  logic [63:0] dout    [2];
  logic        dvalid  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_iter_unit #(.SIGNED(1'b0)) u_divu (
    .clk                    (clk),
    .resetn                 (resetn),
    .s_axis_divisor_tdata   (b_data[0]),
    .s_axis_divisor_tvalid  (b_valid[0]),
    .s_axis_divisor_tready  (b_ready[0]),
    .s_axis_dividend_tdata  (a_data[0]),
    .s_axis_dividend_tvalid (a_valid[0]),
    .s_axis_dividend_tready (a_ready[0]),
    .m_axis_dout_tdata      (dout[0]),
    .m_axis_dout_tvalid     (dvalid[0])
  );

  div_iter_unit #(.SIGNED(1'b1)) u_div (
    .clk                    (clk),
    .resetn                 (resetn),
    .s_axis_divisor_tdata   (b_data[1]),
    .s_axis_divisor_tvalid  (b_valid[1]),
    .s_axis_divisor_tready  (b_ready[1]),
    .s_axis_dividend_tdata  (a_data[1]),
    .s_axis_dividend_tvalid (a_valid[1]),
    .s_axis_dividend_tready (a_ready[1]),
    .m_axis_dout_tdata      (dout[1]),
    .m_axis_dout_tvalid     (dvalid[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference result computed with plain integer arithmetic.
  function automatic logic [63:0] model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    longint      sa, sb;
    if (b == 32'd0) begin
      q = (sgn && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
    return {q, r};
  endfunction

  // Edges from capture to the edge that raises the result pulse.
  function automatic int lat_of(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 32'd0) ? 0 : 32;
`else
    return 32;
`endif
  endfunction

  // ---------------------------------------------------------------------
  // Behavioural model: operand capture plus "busy until edge N" timing
  // ---------------------------------------------------------------------
  int          edge_cnt = 0;        // count of non-reset rising edges seen
  bit          m_have_a [2] = '{default: 1'b0};
  bit          m_have_b [2] = '{default: 1'b0};
  bit          m_busy   [2] = '{default: 1'b0};
  logic [31:0] m_a      [2] = '{default: '0};
  logic [31:0] m_b      [2] = '{default: '0};
  int          m_pulse  [2] = '{default: 0};
  int          m_until  [2] = '{default: 0};
  logic [63:0] m_pend   [2] = '{default: '0};
  logic [63:0] m_dout   [2] = '{default: '0};

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        for (int k = 0; k < 2; k++) begin
          m_have_a[k] = 1'b0;
          m_have_b[k] = 1'b0;
          m_busy[k]   = 1'b0;
          m_dout[k]   = '0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (m_busy[k] && edge_cnt == m_pulse[k]) m_dout[k] = m_pend[k];
          if (!m_busy[k] || edge_cnt > m_until[k]) begin
            if ((m_have_a[k] || a_valid[k]) && (m_have_b[k] || b_valid[k])) begin
              m_pend[k]  = model_div(k == 1, m_have_a[k] ? m_a[k] : a_data[k],
                                     m_have_b[k] ? m_b[k] : b_data[k]);
              m_pulse[k] = edge_cnt + lat_of(m_have_b[k] ? m_b[k] : b_data[k]);
              m_until[k] = m_pulse[k] + 1;
              m_busy[k]  = 1'b1;
              if (m_pulse[k] == edge_cnt) m_dout[k] = m_pend[k];
              m_have_a[k] = 1'b0;
              m_have_b[k] = 1'b0;
            end else begin
              if (a_valid[k] && !m_have_a[k]) begin
                m_have_a[k] = 1'b1;
                m_a[k]      = a_data[k];
              end
              if (b_valid[k] && !m_have_b[k]) begin
                m_have_b[k] = 1'b1;
                m_b[k]      = b_data[k];
              end
            end
          end
        end
        edge_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Compare loop: every falling edge, both instances, all outputs
  // ---------------------------------------------------------------------
  int          pulse_cnt  [2] = '{default: 0};
  int          last_pulse [2] = '{default: 0};
  logic [63:0] last_dout  [2] = '{default: '0};

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("ready_divisor[%0d]", k), b_ready[k],
              (!m_busy[k] || edge_cnt - 1 >= m_until[k]) && !m_have_b[k]);
        check($sformatf("ready_dividend[%0d]", k), a_ready[k],
              (!m_busy[k] || edge_cnt - 1 >= m_until[k]) && !m_have_a[k]);
        check($sformatf("dout_valid[%0d]", k), dvalid[k],
              resetn && m_busy[k] && (edge_cnt - 1 == m_pulse[k]));
        check($sformatf("dout_data[%0d]", k), dout[k], m_dout[k]);
        if (dvalid[k] === 1'b1) begin
          pulse_cnt[k]++;
          last_pulse[k] = edge_cnt - 1;
          last_dout[k]  = dout[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  // Present both operands together and hold them until the edge that
  // captures them. cap returns the index of that edge.
  task automatic send(input int k, input logic [31:0] a, input logic [31:0] b, output int cap);
    bit got;
    got = 1'b0;
    cap = -1;
    @(negedge clk);
    a_data[k]  = a;
    b_data[k]  = b;
    a_valid[k] = 1'b1;
    b_valid[k] = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      if (a_ready[k] && b_ready[k]) begin
        cap = edge_cnt;
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) check($sformatf("send_timeout[%0d]", k), 1'b0, 1'b1);
    @(negedge clk);
    a_valid[k] = 1'b0;
    b_valid[k] = 1'b0;
  endtask

  // Wait for the next result pulse after pulse number pc, then check its
  // data and its latency from edge cap.
  task automatic await(input int k, input int pc, input string name, input logic [63:0] exp,
                       input int cap, input int lat);
    for (int n = 0; n < 80 && pulse_cnt[k] == pc; n++) @(negedge clk);
    #1;
    if (pulse_cnt[k] == pc) begin
      check({name, "_timeout"}, 1'b0, 1'b1);
    end else begin
      check({name, "_data"}, last_dout[k], exp);
      check({name, "_latency"}, 64'(last_pulse[k] - cap), 64'(lat));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int cap, cap2, pc;
  bit got;

  initial begin
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a_data[k] = '0; b_data[k] = '0; a_valid[k] = 1'b0; b_valid[k] = 1'b0;
    end

    // Pin the model to hand-computed values.
    check("pin_u_100_7",  model_div(1'b0, 32'd100, 32'd7),               {32'h0000000E, 32'h00000002});
    check("pin_s_m100_7", model_div(1'b1, 32'hFFFFFF9C, 32'd7),          {32'hFFFFFFF2, 32'hFFFFFFFE});
    check("pin_s_ovf",    model_div(1'b1, 32'h80000000, 32'hFFFFFFFF),   {32'h80000000, 32'h00000000});
    check("pin_u_ovf",    model_div(1'b0, 32'h80000000, 32'hFFFFFFFF),   {32'h00000000, 32'h80000000});
    check("pin_s_dz_neg", model_div(1'b1, 32'hFFFFFFF0, 32'd0),          {32'h00000001, 32'hFFFFFFF0});

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs_u", {b_ready[0], a_ready[0], dvalid[0], dout[0]}, {3'b110, 64'd0});
    check("reset_outputs_s", {b_ready[1], a_ready[1], dvalid[1], dout[1]}, {3'b110, 64'd0});
    #1 resetn = 1'b1;

    // DIVU 100/7, both operands in the same cycle
    pc = pulse_cnt[0];
    send(0, 32'd100, 32'd7, cap);
    await(0, pc, "u_100_7", {32'h0000000E, 32'h00000002}, cap, 32);

    // DIV -100/7, dividend first, divisor three cycles later
    pc = pulse_cnt[1];
    @(negedge clk);
    a_data[1] = 32'hFFFFFF9C; a_valid[1] = 1'b1;
    @(negedge clk);
    a_valid[1] = 1'b0; a_data[1] = 32'hDEADBEEF;
    @(negedge clk);
    #1 check("stagger_dividend_held", {a_ready[1], b_ready[1]}, 2'b01);
    @(negedge clk);
    b_data[1] = 32'd7; b_valid[1] = 1'b1; cap = edge_cnt;
    @(negedge clk);
    b_valid[1] = 1'b0;
    await(1, pc, "s_m100_7", {32'hFFFFFFF2, 32'hFFFFFFFE}, cap, 32);

    // Overflow operands on both instances
    pc = pulse_cnt[1];
    send(1, 32'h80000000, 32'hFFFFFFFF, cap);
    await(1, pc, "s_ovf", {32'h80000000, 32'h00000000}, cap, 32);
    pc = pulse_cnt[0];
    send(0, 32'h80000000, 32'hFFFFFFFF, cap);
    await(0, pc, "u_ovf", {32'h00000000, 32'h80000000}, cap, 32);

    // Divide by zero
    pc = pulse_cnt[0];
    send(0, 32'h12345678, 32'd0, cap);
    await(0, pc, "u_div0", {32'hFFFFFFFF, 32'h12345678}, cap, lat_of(32'd0));
    pc = pulse_cnt[1];
    send(1, 32'hFFFFFFF0, 32'd0, cap);
    await(1, pc, "s_div0_neg", {32'h00000001, 32'hFFFFFFF0}, cap, lat_of(32'd0));

    // Reset at iteration 10 abandons the operation
    pc = pulse_cnt[0];
    send(0, 32'd50, 32'd5, cap);
    repeat (9) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check("midop_reset_outputs", {b_ready[0], a_ready[0], dvalid[0], dout[0]}, {3'b110, 64'd0});
    @(negedge clk);
    #2 resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("midop_no_pulse", 64'(pulse_cnt[0]), 64'(pc));
    send(0, 32'd9, 32'd3, cap);
    await(0, pc, "u_9_3", {32'h00000003, 32'h00000000}, cap, 32);

    // Producer keeps valid high with new data during CALC
    pc = pulse_cnt[1];
    send(1, 32'd1000, 32'hFFFFFFFD, cap);
    a_data[1] = 32'hFFFFFFF9; b_data[1] = 32'd2;
    a_valid[1] = 1'b1; b_valid[1] = 1'b1;
    got = 1'b0;
    cap2 = -1;
    for (int n = 0; n < 100 && !got; n++) begin
      if (a_ready[1] && b_ready[1]) begin
        cap2 = edge_cnt;
        got  = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    check("overlap_first_result", last_dout[1], {32'hFFFFFEB3, 32'h00000001});
    check("overlap_first_count", 64'(pulse_cnt[1]), 64'(pc + 1));
    check("overlap_second_accept_edge", 64'(cap2 - cap), 64'd34);
    @(negedge clk);
    a_valid[1] = 1'b0; b_valid[1] = 1'b0;
    await(1, pc + 1, "overlap_second", {32'hFFFFFFFD, 32'hFFFFFFFF}, cap2, 32);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Iterative 32-bit radix-2 restoring divider; the responder end of the divider stream interface that the execute stage drives.
- Execute stage presents divisor and dividend on independent valid/ready channels, stalls until the one-cycle result pulse, then writes quotient to LO and remainder to HI.
- Built as the in-house replacement for vendor divider cores; one instance per signedness (SIGNED=1 for DIV, SIGNED=0 for DIVU).

Parameters:
- SIGNED, 1, 1 = operands and results two's-complement (DIV); 0 = unsigned (DIVU).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- s_axis_divisor_tdata  input  32  divisor operand.
- s_axis_divisor_tvalid  input  1  divisor valid.
- s_axis_divisor_tready  output  1  divisor accepted when tvalid&&tready at a rising edge.
- s_axis_dividend_tdata  input  32  dividend operand.
- s_axis_dividend_tvalid  input  1  dividend valid.
- s_axis_dividend_tready  output  1  dividend accepted when tvalid&&tready at a rising edge.
- m_axis_dout_tdata  output  64  {quotient[63:32], remainder[31:0]}.
- m_axis_dout_tvalid  output  1  one-cycle result pulse; no back-pressure.

Behaviour:
- Reset (async, resetn=0): state IDLE, both capture flags 0, counter 0; tready outputs 1, dout_tvalid 0, dout_tdata 0. Reset mid-operation abandons the division; no result pulse is produced.
- States: IDLE, CALC, OUT.
- IDLE: divisor_tready = !divisor_captured; dividend_tready = !dividend_captured. Each channel captures independently, in the same cycle or in different cycles. A captured channel holds its operand and drops tready until the operation completes.
- IDLE -> CALC: at the edge where the second operand is captured (or both together), the operands are latched. With SIGNED=1, |dividend| and |divisor| are loaded, and sign_q = a[31]^b[31] and sign_r = a[31] are recorded. The counter is cleared.
- CALC: one iteration per edge. The partial remainder shifts left by 1 and takes in the next dividend MSB. Then trial = rem - divisor. If trial >= 0, rem = trial and q bit = 1; otherwise q bit = 0. The counter increments.
- CALC -> OUT: at the 32nd iteration edge. At that edge, dout_tdata is registered with sign correction applied: quotient negated if sign_q, remainder negated if sign_r (SIGNED=1 only). Capture flags clear.
- OUT: dout_tvalid = 1 for exactly one cycle, tready outputs 0. OUT -> IDLE unconditionally.
- Latency: tvalid is high in the 33rd cycle after the operand-completing handshake edge. A new operand can be accepted in the cycle after OUT.
- tready outputs are 0 throughout CALC and OUT. tvalid asserted by the producer during these states is ignored and not captured.
- dout_tdata holds its last value after the tvalid pulse until the next OUT.
- Divide by zero (divisor=0):
  - Unsigned result: quotient 0xFFFFFFFF, remainder dividend.
  - Signed result: quotient 0xFFFFFFFF when dividend >= 0, else 0x00000001; remainder dividend.
- Overflow 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0.
- Arithmetic: 33-bit trial subtract, no saturation. Remainder sign follows dividend; quotient truncates toward zero.

Optional Feature:
- Macro DIV_ZERO_FAST_EN.
- Defined: if the latched divisor is 0, IDLE goes directly to OUT at the capture edge. dout_tdata is loaded with the divide-by-zero values above, and tvalid pulses in the cycle after capture (latency 1).
- Undefined: divisor 0 runs the full 32 iterations, producing the identical values at the normal latency.
- All other behaviour is identical with or without the macro.

Test Plan:
- SIGNED=0: divisor 7 and dividend 100 in the same cycle -> tvalid in 33rd cycle after, tdata = {0x0000000E, 0x00000002}; tready low until the cycle after the pulse.
- SIGNED=1: dividend 0xFFFFFF9C (-100) at cycle 0, divisor 7 at cycle 3 -> timing counts from cycle 3; tdata = {0xFFFFFFF2, 0xFFFFFFFE}.
- SIGNED=1: 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0x00000000}; SIGNED=0: same operands -> {0x00000000, 0x80000000}.
- Divisor 0, dividend 0x12345678, SIGNED=0 -> {0xFFFFFFFF, 0x12345678}. Latency 33 without DIV_ZERO_FAST_EN, 1 with it.
- resetn pulsed low at iteration 10 -> outputs immediately at reset values, no tvalid. A fresh 9/3 op afterwards -> {0x00000003, 0x00000000}.
- Producer holds both tvalid high during CALC with new data -> not captured; the second op is accepted only after OUT and yields its own correct result.
